// File: rtl/archer_shot_ctl.sv
// Archer attack sequencer (IDLE -> DRAW -> FIRE -> COOLDOWN) and arrow projectile pool.
// Spawns arrows on FIRE and moves every live arrow once per frame tick.
module archer_shot_ctl #(
    parameter int unsigned NUM_ARROWS      = 4,
    parameter int unsigned DRAW_FRAMES     = 8,
    parameter int unsigned COOLDOWN_FRAMES = 20,
    parameter int unsigned ARROW_SPEED     = 8,
    parameter int unsigned SPAWN_DX        = 20,
    parameter int unsigned SPAWN_DY        = 15,
    parameter int unsigned SCREEN_W        = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     mouse_clicked,
    input  logic [11:0]              pos_x,
    input  logic [11:0]              pos_y,
    input  logic [11:0]              xpos_MouseCtl,
    input  logic [NUM_ARROWS-1:0]    arrow_hit,
    output logic                     draw_weapon,
    output logic                     flip_hor_archer,
    output logic                     fire_pulse,
    output logic                     fire_dropped,
    output logic [NUM_ARROWS-1:0]    arrow_active,
    output logic [NUM_ARROWS-1:0]    arrow_dir,
    output logic [12*NUM_ARROWS-1:0] arrow_x,
    output logic [12*NUM_ARROWS-1:0] arrow_y
);

    localparam int unsigned CNT_MAX = (DRAW_FRAMES > COOLDOWN_FRAMES) ? DRAW_FRAMES : COOLDOWN_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned POS_W   = 12;

    typedef enum logic [1:0] {IDLE, DRAW, FIRE, COOLDOWN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flip_d;
    logic               click_prev;
    logic               click_edge_c;
    logic               fire_c;
    logic [NUM_ARROWS-1:0] spawn_oh_c;
    logic [POS_W-1:0]   spawn_x_c;
    logic [POS_W-1:0]   spawn_y_c;

    logic [POS_W-1:0]   ax_q [NUM_ARROWS];
    logic [POS_W-1:0]   ay_q [NUM_ARROWS];
    logic [POS_W-1:0]   ax_d [NUM_ARROWS];
    logic [POS_W-1:0]   ay_d [NUM_ARROWS];
    logic [NUM_ARROWS-1:0] act_d;
    logic [NUM_ARROWS-1:0] dir_d;

    assign click_edge_c = mouse_clicked & ~click_prev;
    assign fire_c       = (state_q == FIRE);
    // Lowest clear bit of the registered active mask; zero when the pool is full.
    assign spawn_oh_c   = ~arrow_active & (arrow_active + NUM_ARROWS'(1));
    assign spawn_x_c    = flip_hor_archer ? (pos_x - POS_W'(SPAWN_DX)) : (pos_x + POS_W'(SPAWN_DX));
    assign spawn_y_c    = pos_y + POS_W'(SPAWN_DY);

    // Attack FSM next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flip_d  = flip_hor_archer;
        unique case (state_q)
            IDLE: begin
                if (click_edge_c) begin
                    state_d = DRAW;
                    cnt_d   = '0;
                    flip_d  = (xpos_MouseCtl <= pos_x);
                end
            end
            DRAW: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(DRAW_FRAMES - 1)) begin
                        state_d = FIRE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIRE: begin
                state_d = COOLDOWN;
                cnt_d   = '0;
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_W'(COOLDOWN_FRAMES - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            click_prev      <= 1'b0;
            flip_hor_archer <= 1'b0;
            draw_weapon     <= 1'b0;
            fire_pulse      <= 1'b0;
            fire_dropped    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            click_prev      <= mouse_clicked;
            flip_hor_archer <= flip_d;
            draw_weapon     <= (state_d == DRAW) || (state_d == FIRE);
            fire_pulse      <= fire_c & (|spawn_oh_c);
            fire_dropped    <= fire_c & ~(|spawn_oh_c);
        end
    end

    // Per-slot update: spawn, then hit, then motion (13-bit bounds, no wrap).
    always_comb begin
        for (int i = 0; i < NUM_ARROWS; i++) begin
            act_d[i] = arrow_active[i];
            dir_d[i] = arrow_dir[i];
            ax_d[i]  = ax_q[i];
            ay_d[i]  = ay_q[i];
            if (fire_c && spawn_oh_c[i]) begin
                act_d[i] = 1'b1;
                dir_d[i] = flip_hor_archer;
                ax_d[i]  = spawn_x_c;
                ay_d[i]  = spawn_y_c;
            end else if (arrow_active[i] && arrow_hit[i]) begin
                act_d[i] = 1'b0;
            end else if (arrow_active[i] && frame_tick) begin
                if (arrow_dir[i]) begin
                    if (ax_q[i] < POS_W'(ARROW_SPEED)) begin
                        act_d[i] = 1'b0;
                    end else begin
                        ax_d[i] = ax_q[i] - POS_W'(ARROW_SPEED);
                    end
                end else begin
                    if (({1'b0, ax_q[i]} + 13'(ARROW_SPEED)) > 13'(SCREEN_W - 1)) begin
                        act_d[i] = 1'b0;
                    end else begin
                        ax_d[i] = ax_q[i] + POS_W'(ARROW_SPEED);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arrow_active <= '0;
            arrow_dir    <= '0;
            for (int i = 0; i < NUM_ARROWS; i++) begin
                ax_q[i] <= '0;
                ay_q[i] <= '0;
            end
        end else begin
            arrow_active <= act_d;
            arrow_dir    <= dir_d;
            for (int i = 0; i < NUM_ARROWS; i++) begin
                ax_q[i] <= ax_d[i];
                ay_q[i] <= ay_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_ARROWS; g++) begin : g_pack
        assign arrow_x[12*g +: 12] = ax_q[g];
        assign arrow_y[12*g +: 12] = ay_q[g];
    end

endmodule

// File: tb/tb_archer_shot_ctl.sv
// Directed self-checking bench for archer_shot_ctl with default parameters.
module tb_archer_shot_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        mouse_clicked = 1'b0;
    logic [11:0] pos_x = '0;
    logic [11:0] pos_y = '0;
    logic [11:0] xpos_MouseCtl = '0;
    logic [3:0]  arrow_hit = '0;
    logic        draw_weapon;
    logic        flip_hor_archer;
    logic        fire_pulse;
    logic        fire_dropped;
    logic [3:0]  arrow_active;
    logic [3:0]  arrow_dir;
    logic [47:0] arrow_x;
    logic [47:0] arrow_y;

    int checks = 0;
    int errors = 0;

    archer_shot_ctl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .mouse_clicked(mouse_clicked),
        .pos_x(pos_x), .pos_y(pos_y), .xpos_MouseCtl(xpos_MouseCtl), .arrow_hit(arrow_hit),
        .draw_weapon(draw_weapon), .flip_hor_archer(flip_hor_archer),
        .fire_pulse(fire_pulse), .fire_dropped(fire_dropped),
        .arrow_active(arrow_active), .arrow_dir(arrow_dir),
        .arrow_x(arrow_x), .arrow_y(arrow_y)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; frame_tick = 1'b0; mouse_clicked = 1'b0; arrow_hit = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_click();
        mouse_clicked = 1'b1;
        @(negedge clk);
        mouse_clicked = 1'b0;
    endtask

    // Click then 8 draw ticks; returns at the cycle where fire_pulse/fire_dropped is visible.
    task automatic do_attack();
        do_click();
        do_ticks(8);
    endtask

    task automatic test_reset();
        int rises = 0;
        int fires = 0;
        logic prev_dw = 1'b0;
        do_reset();
        checks++; if (draw_weapon !== 1'b0 || flip_hor_archer !== 1'b0 || fire_pulse !== 1'b0 || fire_dropped !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: got dw=%b flip=%b fp=%b fd=%b, expected all 0", draw_weapon, flip_hor_archer, fire_pulse, fire_dropped);
        end
        checks++; if (arrow_active !== 4'h0 || arrow_dir !== 4'h0 || arrow_x !== 48'h0 || arrow_y !== 48'h0) begin
            errors++; $display("FAIL reset_arrows: got act=%h dir=%h x=%h y=%h, expected all 0", arrow_active, arrow_dir, arrow_x, arrow_y);
        end
        pos_x = 12'd500; pos_y = 12'd300; xpos_MouseCtl = 12'd700;
        mouse_clicked = 1'b1;
        for (int c = 0; c < 100; c++) begin
            frame_tick = (c % 2 == 0);
            @(negedge clk);
            if (draw_weapon && !prev_dw) rises++;
            if (fire_pulse) fires++;
            prev_dw = draw_weapon;
        end
        frame_tick = 1'b0; mouse_clicked = 1'b0;
        checks++; if (rises != 1) begin
            errors++; $display("FAIL held_click_draw_entries: got %0d, expected 1", rises);
        end
        checks++; if (fires != 1) begin
            errors++; $display("FAIL held_click_fires: got %0d, expected 1", fires);
        end
    endtask

    task automatic test_fire_right();
        do_reset();
        pos_x = 12'd500; pos_y = 12'd300; xpos_MouseCtl = 12'd700;
        do_click();
        checks++; if (draw_weapon !== 1'b1 || flip_hor_archer !== 1'b0) begin
            errors++; $display("FAIL right_draw_start: got dw=%b flip=%b, expected dw=1 flip=0", draw_weapon, flip_hor_archer);
        end
        do_ticks(7);
        checks++; if (draw_weapon !== 1'b1 || fire_pulse !== 1'b0) begin
            errors++; $display("FAIL right_draw_hold: got dw=%b fp=%b, expected dw=1 fp=0", draw_weapon, fire_pulse);
        end
        do_ticks(1);
        checks++; if (fire_pulse !== 1'b1 || draw_weapon !== 1'b0 || arrow_active !== 4'b0001) begin
            errors++; $display("FAIL right_fire: got fp=%b dw=%b act=%b, expected fp=1 dw=0 act=0001", fire_pulse, draw_weapon, arrow_active);
        end
        checks++; if (arrow_x[11:0] !== 12'd520 || arrow_y[11:0] !== 12'd315 || arrow_dir[0] !== 1'b0) begin
            errors++; $display("FAIL right_spawn: got x=%0d y=%0d dir=%b, expected x=520 y=315 dir=0", arrow_x[11:0], arrow_y[11:0], arrow_dir[0]);
        end
        @(negedge clk);
        checks++; if (fire_pulse !== 1'b0) begin
            errors++; $display("FAIL right_fire_oneshot: got fp=%b, expected 0", fire_pulse);
        end
        do_ticks(1);
        checks++; if (arrow_x[11:0] !== 12'd528 || arrow_active !== 4'b0001) begin
            errors++; $display("FAIL right_move: got x=%0d act=%b, expected x=528 act=0001", arrow_x[11:0], arrow_active);
        end
        do_ticks(19);
    endtask

    task automatic test_fire_left();
        do_reset();
        pos_x = 12'd500; pos_y = 12'd300; xpos_MouseCtl = 12'd500;
        do_click();
        checks++; if (flip_hor_archer !== 1'b1) begin
            errors++; $display("FAIL left_flip: got %b, expected 1", flip_hor_archer);
        end
        do_ticks(8);
        checks++; if (fire_pulse !== 1'b1 || arrow_x[11:0] !== 12'd480 || arrow_dir[0] !== 1'b1 || arrow_y[11:0] !== 12'd315) begin
            errors++; $display("FAIL left_spawn: got fp=%b x=%0d y=%0d dir=%b, expected fp=1 x=480 y=315 dir=1", fire_pulse, arrow_x[11:0], arrow_y[11:0], arrow_dir[0]);
        end
        do_ticks(1);
        checks++; if (arrow_x[11:0] !== 12'd472) begin
            errors++; $display("FAIL left_move: got x=%0d, expected 472", arrow_x[11:0]);
        end
        do_ticks(19);
    endtask

    task automatic test_boundary();
        do_reset();
        pos_x = 12'd992; pos_y = 12'd100; xpos_MouseCtl = 12'd1000;
        do_attack();
        checks++; if (arrow_active !== 4'b0001 || arrow_x[11:0] !== 12'd1012) begin
            errors++; $display("FAIL edge_right_spawn: got act=%b x=%0d, expected act=0001 x=1012", arrow_active, arrow_x[11:0]);
        end
        do_ticks(1);
        checks++; if (arrow_active !== 4'b0001 || arrow_x[11:0] !== 12'd1020) begin
            errors++; $display("FAIL edge_right_1020: got act=%b x=%0d, expected act=0001 x=1020", arrow_active, arrow_x[11:0]);
        end
        do_ticks(1);
        checks++; if (arrow_active !== 4'b0000 || arrow_x[11:0] !== 12'd1020) begin
            errors++; $display("FAIL edge_right_despawn: got act=%b x=%0d, expected act=0000 x=1020", arrow_active, arrow_x[11:0]);
        end
        do_ticks(18);
        pos_x = 12'd27; xpos_MouseCtl = 12'd0;
        do_attack();
        checks++; if (arrow_active !== 4'b0001 || arrow_x[11:0] !== 12'd7 || arrow_dir[0] !== 1'b1) begin
            errors++; $display("FAIL edge_left_spawn: got act=%b x=%0d dir=%b, expected act=0001 x=7 dir=1", arrow_active, arrow_x[11:0], arrow_dir[0]);
        end
        do_ticks(1);
        checks++; if (arrow_active !== 4'b0000) begin
            errors++; $display("FAIL edge_left_despawn: got act=%b, expected 0000", arrow_active);
        end
        do_ticks(19);
    endtask

    task automatic test_pool();
        logic [3:0] exp_act;
        do_reset();
        pos_x = 12'd4000; pos_y = 12'd50; xpos_MouseCtl = 12'd0;
        exp_act = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            do_attack();
            exp_act[n] = 1'b1;
            checks++; if (fire_pulse !== 1'b1 || fire_dropped !== 1'b0 || arrow_active !== exp_act) begin
                errors++; $display("FAIL pool_fill_%0d: got fp=%b fd=%b act=%b, expected fp=1 fd=0 act=%b", n, fire_pulse, fire_dropped, arrow_active, exp_act);
            end
            do_ticks(20);
        end
        do_attack();
        checks++; if (fire_pulse !== 1'b0 || fire_dropped !== 1'b1 || arrow_active !== 4'b1111) begin
            errors++; $display("FAIL pool_dropped: got fp=%b fd=%b act=%b, expected fp=0 fd=1 act=1111", fire_pulse, fire_dropped, arrow_active);
        end
        do_ticks(20);
        arrow_hit = 4'b0010;
        @(negedge clk);
        arrow_hit = 4'b0000;
        checks++; if (arrow_active !== 4'b1101) begin
            errors++; $display("FAIL pool_hit: got act=%b, expected 1101", arrow_active);
        end
        do_attack();
        checks++; if (fire_pulse !== 1'b1 || arrow_active !== 4'b1111 || arrow_x[23:12] !== 12'd3980) begin
            errors++; $display("FAIL pool_reuse: got fp=%b act=%b x1=%0d, expected fp=1 act=1111 x1=3980", fire_pulse, arrow_active, arrow_x[23:12]);
        end
        do_ticks(20);
    endtask

    task automatic test_cooldown_ignore();
        int seen = 0;
        do_reset();
        pos_x = 12'd500; pos_y = 12'd300; xpos_MouseCtl = 12'd700;
        do_attack();
        do_ticks(5);
        do_click();
        @(negedge clk);
        do_click();
        checks++; if (draw_weapon !== 1'b0) begin
            errors++; $display("FAIL cooldown_click: got dw=%b, expected 0", draw_weapon);
        end
        do_ticks(15);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (draw_weapon) seen++;
        end
        checks++; if (seen != 0) begin
            errors++; $display("FAIL cooldown_no_queue: got %0d draw cycles, expected 0", seen);
        end
        do_click();
        checks++; if (draw_weapon !== 1'b1) begin
            errors++; $display("FAIL idle_after_cooldown: got dw=%b, expected 1", draw_weapon);
        end
        do_ticks(8);
        do_ticks(20);
    endtask

    task automatic test_reset_mid();
        do_reset();
        pos_x = 12'd4000; pos_y = 12'd50; xpos_MouseCtl = 12'd0;
        do_attack(); do_ticks(20);
        do_attack(); do_ticks(20);
        do_click();
        do_ticks(2);
        checks++; if (arrow_active !== 4'b0011 || draw_weapon !== 1'b1 || flip_hor_archer !== 1'b1) begin
            errors++; $display("FAIL mid_pre_reset: got act=%b dw=%b flip=%b, expected act=0011 dw=1 flip=1", arrow_active, draw_weapon, flip_hor_archer);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (arrow_active !== 4'h0 || arrow_dir !== 4'h0 || arrow_x !== 48'h0 || arrow_y !== 48'h0 ||
                      draw_weapon !== 1'b0 || flip_hor_archer !== 1'b0 || fire_pulse !== 1'b0 || fire_dropped !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got act=%b dir=%b x=%h y=%h dw=%b flip=%b, expected all 0", arrow_active, arrow_dir, arrow_x, arrow_y, draw_weapon, flip_hor_archer);
        end
        rst = 1'b0;
        do_ticks(8);
        checks++; if (fire_pulse !== 1'b0 || draw_weapon !== 1'b0) begin
            errors++; $display("FAIL mid_reset_idle: got fp=%b dw=%b, expected 0 0", fire_pulse, draw_weapon);
        end
    endtask

    initial begin
        test_reset();
        test_fire_right();
        test_fire_left();
        test_boundary();
        test_pool();
        test_cooldown_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
